// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Holds the controller state enum, the default operand width and the iteration-counter width.
package seq_divider_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A counter needs at least one bit, even for the smallest operand width.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_divider_addsub.sv
// Parameterised ripple-carry add/subtract: S = A + (B ^ ctrl) + ctrl.
// With ctrl=1 this gives A - B, and Cout=1 means no borrow occurred.
module addsub_n #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ctrl,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_bx;

    assign w_c[0] = i_ctrl;

    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign w_bx[g]    = i_b[g] ^ i_ctrl;
        assign o_s[g]     = i_a[g] ^ w_bx[g] ^ w_c[g];
        assign w_c[g + 1] = (i_a[g] & w_bx[g]) | (w_c[g] & (i_a[g] ^ w_bx[g]));
    end

    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a
// shared subtractor, with a start/busy/done handshake and divide-by-zero flag.
//
// state | meaning
// IDLE  | waiting for start; start is only accepted here
// CALC  | one restoring iteration per clock, WIDTH iterations total
// DONE  | one-cycle done pulse, results valid, then back to IDLE
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_div_zero;

    logic [WIDTH:0]   w_rp;
    logic [WIDTH:0]   w_trial;
    logic             w_cout;
    logic             w_fits;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;

    assign w_rp = {r_r, r_q[WIDTH-1]};

    addsub_n #(
        .WIDTH (WIDTH + 1)
    ) u_addsub (
        .i_a    (w_rp),
        .i_b    ({1'b0, r_m}),
        .i_ctrl (1'b1),
        .o_s    (w_trial),
        .o_cout (w_cout)
    );

    // Since R' < 2*M, a successful subtract always leaves the trial MSB clear;
    // folding it in keeps the whole subtractor result consumed.
    assign w_fits   = w_cout & ~w_trial[WIDTH];
    assign w_r_next = w_fits ? w_trial[WIDTH-1:0] : w_rp[WIDTH-1:0];
    assign w_q_next = {r_q[WIDTH-2:0], w_fits};
    assign w_last   = (r_count == CW'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = (i_divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            r_r        <= '0;
            r_m        <= '0;
            r_count    <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_div_zero <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (i_divisor != '0) begin
                            r_q        <= i_dividend;
                            r_m        <= i_divisor;
                            r_r        <= '0;
                            r_count    <= '0;
                            r_div_zero <= 1'b0;
                        end else begin
                            r_quot     <= '1;
                            r_rem      <= i_dividend;
                            r_div_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_q     <= w_q_next;
                    r_r     <= w_r_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_quot <= w_q_next;
                        r_rem  <= w_r_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;
    assign o_div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): directed cases, handshake
// corner cases, mid-operation reset, random traffic and an exhaustive sweep.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_div_zero  (o_div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer division, with the defined divide-by-zero result.
    function automatic int ref_q(input int n, input int d);
        return (d == 0) ? (1 << W) - 1 : n / d;
    endfunction

    function automatic int ref_r(input int n, input int d);
        return (d == 0) ? n : n % d;
    endfunction

    // Counts cycles after the start edge until done is seen (sampled at negedge).
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (o_done) return;
        end
        cyc = -1;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_div(input int n, input int d);
        int cyc;
        i_start    = 1'b1;
        i_dividend = W'(n);
        i_divisor  = W'(d);
        @(posedge clk);
        #1 i_start = 1'b0;
        i_dividend = W'($urandom);
        i_divisor  = W'($urandom);
        wait_done(cyc);
        chk($sformatf("latency %0d/%0d", n, d), cyc, (d == 0) ? 1 : W + 1);
        chk($sformatf("busy_in_done %0d/%0d", n, d), int'(o_busy), 1);
        chk($sformatf("quot %0d/%0d", n, d), int'(o_quotient), ref_q(n, d));
        chk($sformatf("rem %0d/%0d", n, d), int'(o_remainder), ref_r(n, d));
        chk($sformatf("dz %0d/%0d", n, d), int'(o_div_zero), (d == 0) ? 1 : 0);
        @(negedge clk);
        chk($sformatf("done_pulse %0d/%0d", n, d), int'(o_done), 0);
        chk($sformatf("idle_busy %0d/%0d", n, d), int'(o_busy), 0);
        chk($sformatf("quot_hold %0d/%0d", n, d), int'(o_quotient), ref_q(n, d));
    endtask

    initial begin
        int  cyc;
        int  cyc2;
        bit  seen_done;

        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        #12;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_quot", int'(o_quotient), 0);
        chk("rst_rem", int'(o_remainder), 0);
        chk("rst_dz", int'(o_div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(13, 3);
        run_div(15, 1);
        run_div(15, 15);
        run_div(2, 9);
        run_div(7, 0);
        run_div(9, 2);

        // start held high through CALC/DONE: second request only taken from IDLE
        i_start    = 1'b1;
        i_dividend = 4'd13;
        i_divisor  = 4'd3;
        @(posedge clk);
        #1;
        i_dividend = 4'd6;
        i_divisor  = 4'd2;
        wait_done(cyc);
        chk("hold_latency", cyc, W + 1);
        chk("hold_quot1", int'(o_quotient), 4);
        chk("hold_rem1", int'(o_remainder), 1);
        wait_done(cyc2);
        chk("hold_done_to_done", cyc2, W + 2);
        chk("hold_quot2", int'(o_quotient), 3);
        chk("hold_rem2", int'(o_remainder), 0);
        i_start = 1'b0;
        @(negedge clk);
        chk("hold_idle", int'(o_busy), 0);

        // reset during the second CALC cycle
        i_start    = 1'b1;
        i_dividend = 4'd11;
        i_divisor  = 4'd2;
        @(posedge clk);
        #1 i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_done", int'(o_done), 0);
        chk("mid_rst_quot", int'(o_quotient), 0);
        chk("mid_rst_rem", int'(o_remainder), 0);
        chk("mid_rst_dz", int'(o_div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_done || o_busy) seen_done = 1'b1;
        end
        chk("no_done_after_rst", int'(seen_done), 0);
        run_div(11, 2);

        // random traffic with random idle gaps
        for (int k = 0; k < 40; k++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) @(negedge clk);
            run_div(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        for (int n = 0; n < 16; n++) begin
            for (int d = 0; d < 16; d++) begin
                run_div(n, d);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
